dmem_mmio: RTL



---
 rtl/dmem_mmio.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_mmio.sv
// Data memory with single-cycle combinational loads: word RAM plus an MMIO window holding
// LED, free-running cycle counter, byte TX FIFO and sticky STATUS. Optional: DMEM_MISALIGN_TRAP_EN.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic [7:0]  led,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        fault
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = $clog2(TX_DEPTH + 1);
  localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);
  localparam logic [CW-1:0] CountFull = CW'(TX_DEPTH);

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  // State
  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [7:0]    led_q, led_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fault_q, fault_d;

  // Decode
  logic [31:0]   word_addr;
  logic          misalign;
  logic          ram_hit, led_hit, cycle_hit, txd_hit, status_hit, unmapped;
  logic          wr_ok;
  logic [AW-1:0] ram_idx;

  // FIFO control
  logic          empty, full, push_req, push, pop, overflow_set, fault_set;
  logic [7:0]    count8;

  always_comb begin
    word_addr  = {dmem_addr[31:2], 2'b00};
    misalign   = TrapEn & (|dmem_addr[1:0]);
    ram_hit    = (dmem_addr < RamBytes);
    led_hit    = (word_addr == MMIO_BASE);
    cycle_hit  = (word_addr == MMIO_BASE + 32'h4);
    txd_hit    = (word_addr == MMIO_BASE + 32'h8);
    status_hit = (word_addr == MMIO_BASE + 32'hC);
    unmapped   = ~(ram_hit | led_hit | cycle_hit | txd_hit | status_hit);
    wr_ok      = dmem_we & ~misalign;
    ram_idx    = dmem_addr[AW+1:2];
  end

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CountFull);
    count8       = 8'(count_q);
    pop          = ~empty & tx_ready;
    push_req     = wr_ok & txd_hit;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    push         = push_req & (~full | pop);
    overflow_set = push_req & full & ~pop;
    fault_set    = (dmem_we & unmapped) | misalign;
  end

  always_comb begin
    led_d = led_q;
    if (wr_ok && led_hit) led_d = dmem_wdata[7:0];

    cycle_d = (wr_ok && cycle_hit) ? dmem_wdata : cycle_q + 32'd1;

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Set wins over a same-cycle write-1-to-clear.
    overflow_d = overflow_set |
                 (overflow_q & ~(wr_ok & status_hit & dmem_wdata[2]));
    fault_d    = fault_set |
                 (fault_q & ~(wr_ok & status_hit & dmem_wdata[3]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      cycle_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      led_q      <= led_d;
      cycle_q    <= cycle_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      fault_q    <= fault_d;
    end
  end

  // Storage arrays are never reset; reset still blocks same-cycle writes into them.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok && ram_hit) ram_q[ram_idx] <= dmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= dmem_wdata[7:0];
  end

  always_comb begin
    dmem_rdata = '0;
    if (misalign)        dmem_rdata = '0;
    else if (ram_hit)    dmem_rdata = ram_q[ram_idx];
    else if (led_hit)    dmem_rdata = {24'b0, led_q};
    else if (cycle_hit)  dmem_rdata = cycle_q;
    else if (status_hit) dmem_rdata = {16'b0, count8, 4'b0, fault_q, overflow_q, full, empty};
  end

  assign led      = led_q;
  assign tx_valid = ~empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign fault    = fault_q;

endmodule
